// File: rtl/light_mode_ctrl.sv
// Button/switch front end for the LED pattern generator: synchronises and debounces the
// buttons, then steps, loads or auto-advances the 3-bit pattern mode.
module light_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
    parameter int unsigned AUTO_CYCLES     = 500_000_000,
    parameter int unsigned MODE_MAX        = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_load,
    input  logic [2:0] sw_mode,
    input  logic       auto_en,
    output logic [2:0] mode,
    output logic       mode_changed
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned AW = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW-1:0] AUTO_LAST  = AW'(AUTO_CYCLES - 1);
    localparam logic [2:0]    MODE_MAX_L = 3'(MODE_MAX);

    logic [6:0]    raw;
    logic [6:0]    sync1;
    logic [6:0]    sync2;
    logic [2:0]    btn_s;
    logic [2:0]    sw_s;
    logic          auto_s;
    logic [DW-1:0] db_cnt [3];
    logic [2:0]    stable;
    logic [2:0]    stable_d;
    logic [2:0]    press;
    logic          any_press;
    logic [AW-1:0] timer;
    logic          auto_tick;
    logic [2:0]    step_up;
    logic [2:0]    step_down;
    logic [2:0]    mode_nxt;

    assign raw    = {auto_en, sw_mode, btn_load, btn_prev, btn_next};
    assign btn_s  = sync2[2:0];
    assign sw_s   = sync2[5:3];
    assign auto_s = sync2[6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // bit order everywhere: [0]=next, [1]=prev, [2]=load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
            stable   <= '0;
            stable_d <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (btn_s[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= btn_s[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
            stable_d <= stable;
        end
    end

    assign press     = stable & ~stable_d;
    assign any_press = |press;
    assign auto_tick = auto_s && !any_press && (timer == AUTO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (!auto_s || any_press || timer == AUTO_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_comb begin
        step_up   = (mode >= MODE_MAX_L) ? 3'd0 : mode + 3'd1;
        step_down = (mode == 3'd0 || mode > MODE_MAX_L) ? MODE_MAX_L : mode - 3'd1;
        mode_nxt  = mode;
        if (press[2]) begin
            mode_nxt = sw_s;
        end else if (press[0] ^ press[1]) begin
            mode_nxt = press[0] ? step_up : step_down;
        end else if (auto_tick) begin
            mode_nxt = step_up;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode         <= '0;
            mode_changed <= 1'b0;
        end else begin
            mode         <= mode_nxt;
            mode_changed <= (mode_nxt != mode);
        end
    end

endmodule
